// File: rtl/morse_rx_module.sv
// Morse receiver: times marks/spaces on a 1 ms tick, assembles dot/dash characters and flags S-O-S.
// Optional macro MORSE_RX_SOS_LATCH_EN holds SOS_Det until the next key press instead of pulsing it.
module morse_rx_module #(
  parameter int T_1MS       = 50000,
  parameter int DOT_MAX_MS  = 200,
  parameter int MARK_MAX_MS = 1000,
  parameter int CHAR_GAP_MS = 300,
  parameter int WORD_GAP_MS = 700
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Pin_In,
  output logic       Char_Valid,
  output logic [2:0] Char_Len,
  output logic [4:0] Char_Bits,
  output logic       Err_Sig,
  output logic       SOS_Det
);

  localparam int             PW         = (T_1MS > 1) ? $clog2(T_1MS) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(T_1MS - 1);
  localparam logic [10:0]    MS_SAT     = 11'd2047;
  localparam logic [10:0]    DOT_MAX    = 11'(DOT_MAX_MS);
  localparam logic [10:0]    MARK_MAX   = 11'(MARK_MAX_MS);
  localparam logic [10:0]    CHAR_GAP   = 11'(CHAR_GAP_MS);
  localparam logic [10:0]    WORD_GAP   = 11'(WORD_GAP_MS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_MARK, ST_SPACE, ST_GAP, ST_WAIT_REL, ST_SPACE_ERR
  } state_e;

  typedef enum logic [1:0] {TR_0, TR_S, TR_SO} trk_e;

  state_e        state_q, state_d;
  trk_e          trk_q, trk_d;
  logic          pin_meta_q, pin_s_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [10:0]   ms_q, ms_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [4:0]    bits_q, bits_d;
  logic          cv_q, cv_d;
  logic [2:0]    len_q, len_d;
  logic [4:0]    obits_q, obits_d;
  logic          err_q, err_d;
  logic          sos_q, sos_d;
  logic          det;
  logic          tick;
  logic          is_s, is_o;

  assign tick = (presc_q == PRESC_LAST);
  assign is_s = (cnt_q == 3'd3) && (bits_q == 5'b00000);
  assign is_o = (cnt_q == 3'd3) && (bits_q == 5'b00111);

  // State and datapath registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pin_meta_q <= 1'b0;
      pin_s_q    <= 1'b0;
      state_q    <= ST_IDLE;
      trk_q      <= TR_0;
      presc_q    <= '0;
      ms_q       <= '0;
      cnt_q      <= '0;
      bits_q     <= '0;
      cv_q       <= 1'b0;
      len_q      <= '0;
      obits_q    <= '0;
      err_q      <= 1'b0;
      sos_q      <= 1'b0;
    end else begin
      pin_meta_q <= Pin_In;
      pin_s_q    <= pin_meta_q;
      state_q    <= state_d;
      trk_q      <= trk_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      cv_q       <= cv_d;
      len_q      <= len_d;
      obits_q    <= obits_d;
      err_q      <= err_d;
      sos_q      <= sos_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (pin_s_q) state_d = ST_MARK;
      ST_MARK: begin
        if (!pin_s_q)              state_d = (cnt_q == 3'd5) ? ST_SPACE_ERR : ST_SPACE;
        else if (ms_q >= MARK_MAX) state_d = ST_WAIT_REL;
      end
      ST_SPACE, ST_SPACE_ERR: begin
        if (pin_s_q)               state_d = ST_MARK;
        else if (ms_q >= CHAR_GAP) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (pin_s_q)               state_d = ST_MARK;
        else if (ms_q >= WORD_GAP) state_d = ST_IDLE;
      end
      ST_WAIT_REL:  if (!pin_s_q) state_d = ST_GAP;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    ms_d    = (tick && ms_q != MS_SAT) ? ms_q + 11'd1 : ms_q;
    if (state_d != state_q) begin
      presc_d = '0;
      // GAP continues the space already timed in SPACE rather than restarting it
      ms_d    = (state_d == ST_GAP) ? CHAR_GAP : 11'd0;
    end
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    cv_d    = 1'b0;
    len_d   = len_q;
    obits_d = obits_q;
    err_d   = 1'b0;
    trk_d   = trk_q;
    det     = 1'b0;
    unique case (state_q)
      ST_MARK: begin
        if (!pin_s_q) begin
          if (cnt_q == 3'd5) begin
            err_d  = 1'b1;
            cnt_d  = '0;
            bits_d = '0;
          end else begin
            cnt_d  = cnt_q + 3'd1;
            bits_d = {bits_q[3:0], (ms_q >= DOT_MAX)};
          end
        end else if (ms_q >= MARK_MAX) begin
          err_d  = 1'b1;
          cnt_d  = '0;
          bits_d = '0;
        end
      end
      ST_SPACE: begin
        if (!pin_s_q && ms_q >= CHAR_GAP) begin
          cv_d    = 1'b1;
          len_d   = cnt_q;
          obits_d = bits_q;
          cnt_d   = '0;
          bits_d  = '0;
          unique case (trk_q)
            TR_0:    trk_d = is_s ? TR_S : TR_0;
            TR_S:    trk_d = is_o ? TR_SO : (is_s ? TR_S : TR_0);
            TR_SO: begin
              det   = is_s;
              trk_d = is_s ? TR_S : TR_0;
            end
            default: trk_d = TR_0;
          endcase
        end
      end
      ST_GAP: if (!pin_s_q && ms_q >= WORD_GAP) trk_d = TR_0;
      default: ;
    endcase
    if (err_d) trk_d = TR_0;
  end

`ifdef MORSE_RX_SOS_LATCH_EN
  logic pin_prev_q;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) pin_prev_q <= 1'b0;
    else       pin_prev_q <= pin_s_q;
  end
  always_comb sos_d = det ? 1'b1 : ((pin_s_q & ~pin_prev_q) ? 1'b0 : sos_q);
`else
  always_comb sos_d = det;
`endif

  // Output logic
  always_comb begin
    Char_Valid = cv_q;
    Char_Len   = len_q;
    Char_Bits  = obits_q;
    Err_Sig    = err_q;
    SOS_Det    = sos_q;
  end

endmodule

// File: tb/tb_morse_rx_module.sv
// Directed and randomized bench for morse_rx_module against a pattern-level reference model.
module tb_morse_rx_module;
  localparam int  T       = 2;
  localparam int  PER     = 10;
  localparam byte DASH_CH = 8'h2d;
`ifdef MORSE_RX_SOS_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Pin_In;
  logic       Char_Valid;
  logic [2:0] Char_Len;
  logic [4:0] Char_Bits;
  logic       Err_Sig;
  logic       SOS_Det;

  morse_rx_module #(.T_1MS(T)) dut (
    .CLK(CLK), .RSTn(RSTn), .Pin_In(Pin_In),
    .Char_Valid(Char_Valid), .Char_Len(Char_Len), .Char_Bits(Char_Bits),
    .Err_Sig(Err_Sig), .SOS_Det(SOS_Det)
  );

  always #(PER/2) CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  int         cv_cnt = 0, err_cnt = 0, sos_cnt = 0, coinc = 0;
  logic [2:0] cv_len;
  logic [4:0] cv_bits;
  logic       cv_sos;
  time        cv_time, err_time;
  logic       sos_prev = 1'b0;

  // Reference model state: last pending character and characters since word break/error/reset
  string pend = "";
  string hist[$];

  always @(posedge CLK) begin
    #1;
    if (Char_Valid) begin
      cv_cnt++;
      cv_len  = Char_Len;
      cv_bits = Char_Bits;
      cv_sos  = SOS_Det;
      cv_time = $time;
      if (Err_Sig) coinc++;
    end
    if (Err_Sig) begin
      err_cnt++;
      err_time = $time;
    end
    if (SOS_Det && !sos_prev) sos_cnt++;
    sos_prev = SOS_Det;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected in [%0d,%0d]", tag, obs, lo, hi);
    end
  endtask

  task automatic hold(input logic v, input int ms);
    Pin_In = v;
    repeat (ms * T) @(negedge CLK);
  endtask

  // Send one character's marks; 0 for a duration selects a random legal value
  task automatic key(input string pat, input int dot_ms, input int dash_ms, input int eg_ms);
    for (int i = 0; i < pat.len(); i++) begin
      int d;
      if (pat.getc(i) == DASH_CH) d = (dash_ms == 0) ? int'($urandom_range(400, 250)) : dash_ms;
      else                        d = (dot_ms == 0)  ? int'($urandom_range(150, 40))  : dot_ms;
      hold(1'b1, d);
      if (i != pat.len() - 1) hold(1'b0, (eg_ms == 0) ? int'($urandom_range(150, 40)) : eg_ms);
    end
    pend = pat;
  endtask

  task automatic space(input int ms, input string tag);
    int         c0, e0, s0, lat, n;
    time        tf;
    logic [2:0] xl;
    logic [4:0] xb;
    logic       xs, xv;
    c0 = cv_cnt; e0 = err_cnt; s0 = sos_cnt; tf = $time;
    xv = (pend.len() != 0);
    xl = '0; xb = '0; xs = 1'b0;
    if (xv) begin
      xl = 3'(pend.len());
      for (int i = 0; i < pend.len(); i++) xb = {xb[3:0], (pend.getc(i) == DASH_CH)};
      hist.push_back(pend);
      n  = hist.size();
      xs = (n >= 3) && hist[n-3] == "..." && hist[n-2] == "---" && hist[n-1] == "...";
    end
    hold(1'b0, ms);
    check({tag, "/cv_count"}, cv_cnt - c0, xv);
    check({tag, "/err_count"}, err_cnt - e0, 0);
    check({tag, "/sos_count"}, sos_cnt - s0, xs);
    if (xv && cv_cnt - c0 == 1) begin
      check({tag, "/len"}, cv_len, xl);
      check({tag, "/bits"}, cv_bits, xb);
      check({tag, "/sos_with_cv"}, cv_sos, xs);
      lat = int'((cv_time - tf) / PER);
      check_range({tag, "/cv_latency_cycles"}, lat, 300 * T, 300 * T + 8);
      $display("char %s len=%0d bits=%b sos=%0d latency=%0d", tag, cv_len, cv_bits, cv_sos, lat);
    end
    if (ms >= 700) hist.delete();
    pend = "";
  endtask

  initial begin
    int   c0, e0, lat, sel;
    time  tr;
    string p;

    RSTn = 1'b0; Pin_In = 1'b0;
    repeat (4) @(negedge CLK);
    check("reset/Char_Valid", Char_Valid, 0);
    check("reset/Char_Len",   Char_Len,   0);
    check("reset/Char_Bits",  Char_Bits,  0);
    check("reset/Err_Sig",    Err_Sig,    0);
    check("reset/SOS_Det",    SOS_Det,    0);
    RSTn = 1'b1;
    hold(1'b0, 10);

    // Single S
    key("...", 100, 400, 100); space(400, "single_S");

    // S O S, word gap afterwards
    key("...", 100, 400, 100); space(400, "sos_S1");
    key("---", 100, 400, 100); space(400, "sos_O");
    key("...", 100, 400, 100); space(800, "sos_S2");
    check("sos_level_after_gap", SOS_Det, LATCH);

    // Word break between S and O,S
    key("...", 100, 400, 100);
    check("sos_cleared_on_key", SOS_Det, 0);
    space(800, "wb_S");
    key("---", 100, 400, 100); space(400, "wb_O");
    key("...", 100, 400, 100); space(400, "wb_S2");

    // Overlong mark after S,O clears the tracker
    key("...", 100, 400, 100); space(400, "ol_S");
    key("---", 100, 400, 100); space(400, "ol_O");
    c0 = cv_cnt; e0 = err_cnt; tr = $time;
    hold(1'b1, 1100);
    check("overlong/err_count", err_cnt - e0, 1);
    lat = int'((err_time - tr) / PER);
    check_range("overlong/err_latency_cycles", lat, 1000 * T, 1000 * T + 8);
    hold(1'b0, 350);
    check("overlong/cv_after_release", cv_cnt - c0, 0);
    check("overlong/err_total", err_cnt - e0, 1);
    $display("overlong err_latency=%0d", lat);
    hist.delete();
    key("...", 100, 400, 100); space(400, "ol_S_after");
    key("---", 100, 400, 100); space(400, "ol_O_after");
    key("...", 100, 400, 100); space(800, "ol_S_final");

    // Six dots is one element too many
    c0 = cv_cnt; e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 100);
      if (i != 5) hold(1'b0, 100);
    end
    hold(1'b0, 400);
    check("six_dots/err_count", err_cnt - e0, 1);
    check("six_dots/cv_count", cv_cnt - c0, 0);
    $display("six_dots err=%0d cv=%0d", err_cnt - e0, cv_cnt - c0);
    hist.delete();
    key(".", 100, 400, 100); space(400, "E_after_err");

    // Reset in the middle of a character
    key("..", 100, 400, 100);
    hold(1'b0, 50);
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check("midreset/Char_Valid", Char_Valid, 0);
    check("midreset/Char_Len",   Char_Len,   0);
    check("midreset/Char_Bits",  Char_Bits,  0);
    check("midreset/Err_Sig",    Err_Sig,    0);
    check("midreset/SOS_Det",    SOS_Det,    0);
    RSTn = 1'b1;
    pend = "";
    hist.delete();
    space(400, "midreset_idle");
    key("-", 100, 400, 100); space(400, "T_after_reset");

    // Randomized characters biased towards S and O
    for (int k = 0; k < 8; k++) begin
      sel = int'($urandom_range(5, 0));
      if (sel < 2)      p = "...";
      else if (sel < 4) p = "---";
      else begin
        p = "";
        for (int j = 0; j < int'($urandom_range(5, 1)); j++) p = {p, ($urandom_range(1, 0) != 0) ? "-" : "."};
      end
      key(p, 0, 0, 0);
      space(($urandom_range(3, 0) == 0) ? 800 : int'($urandom_range(550, 350)), {"rand_", p});
    end

    check("err_cv_overlap", coinc, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
